// File: rtl/gate_truth_checker.sv
`default_nettype none
// ============================================================================
// Module   : gate_truth_checker
// Purpose  : Drives every input combination into a small combinational gate,
//            samples its output after a settle window and checks it against a
//            parameterised truth table, reporting pass/fail and per-vector errors.
// Revision : 1.0 - initial release
// ============================================================================
module gate_truth_checker #(
    parameter int unsigned              N_IN     = 2,
    parameter logic [(2**N_IN)-1:0]     EXPECTED = 4'b1110,
    parameter int unsigned              SETTLE   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 dut_y,
    output logic [N_IN-1:0]      stim,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_IN:0]        err_count,
    output logic [(2**N_IN)-1:0] fail_vec
);

    localparam logic [1:0]      c_ST_IDLE = 2'd0;
    localparam logic [1:0]      c_ST_HOLD = 2'd1;
    localparam logic [1:0]      c_ST_DONE = 2'd2;
    localparam logic [3:0]      c_SETTLE  = 4'(SETTLE);
    localparam logic [N_IN-1:0] c_LAST    = {N_IN{1'b1}};
    localparam logic [N_IN:0]   c_ONE     = (N_IN+1)'(1);

    logic [1:0]              r_state;
    logic [N_IN-1:0]         r_vec;
    logic [3:0]              r_cnt;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_pass;
    logic [N_IN:0]           r_err_count;
    logic [(2**N_IN)-1:0]    r_fail_vec;
    logic                    w_mismatch;

    assign w_mismatch = (dut_y != EXPECTED[r_vec]);

    // r_vec is held at zero outside HOLD, so it doubles as the registered stimulus.
    assign stim      = r_vec;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = r_err_count;
    assign fail_vec  = r_fail_vec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_vec       <= '0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_count <= '0;
            r_fail_vec  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_vec       <= '0;
                        r_cnt       <= c_SETTLE;
                        r_err_count <= '0;
                        r_fail_vec  <= '0;
                        r_pass      <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= c_ST_HOLD;
                    end
                end
                c_ST_HOLD: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        if (w_mismatch) begin
                            r_err_count       <= r_err_count + c_ONE;
                            r_fail_vec[r_vec] <= 1'b1;
                        end
                        if (r_vec == c_LAST) begin
                            // Final sample folds into pass directly; r_err_count is not yet updated.
                            r_pass  <= (r_err_count == '0) && !w_mismatch;
                            r_vec   <= '0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= c_ST_DONE;
                        end else begin
                            r_vec <= r_vec + 1'b1;
                            r_cnt <= c_SETTLE;
                        end
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gate_truth_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_gate_truth_checker
// Purpose  : Directed bench for gate_truth_checker with OR/AND/stuck-at gate
//            models, at SETTLE=1 and SETTLE=0.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gate_truth_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       start1, start0;
    logic       dut_y1, dut_y0;
    logic [1:0] stim1, stim0;
    logic       busy1, busy0, done1, done0, pass1, pass0;
    logic [2:0] err1, err0;
    logic [3:0] fail1, fail0;
    int         mode;   // 0=OR 1=AND 2=stuck1 3=stuck0
    int         n_vec = 0;
    int         n_err = 0;

    typedef struct {
        int         mode;
        logic [2:0] err;
        logic [3:0] fail;
        logic       pass;
    } vec_t;

    vec_t tbl[4];

    always #5 clk = ~clk;

    function automatic logic gate_model(input int m, input logic [1:0] s);
        case (m)
            0:       return s[1] | s[0];
            1:       return s[1] & s[0];
            2:       return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    assign dut_y1 = gate_model(mode, stim1);
    assign dut_y0 = gate_model(mode, stim0);

    gate_truth_checker #(.N_IN(2), .EXPECTED(4'b1110), .SETTLE(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .dut_y(dut_y1), .stim(stim1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_vec(fail1)
    );

    gate_truth_checker #(.N_IN(2), .EXPECTED(4'b1110), .SETTLE(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .dut_y(dut_y0), .stim(stim0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .fail_vec(fail0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_results(input bit sel, input string tag, input logic [2:0] e_err,
                                 input logic [3:0] e_fail, input logic e_pass);
        check({tag, " pass"}, 32'(sel ? pass0 : pass1), 32'(e_pass));
        check({tag, " err_count"}, 32'(sel ? err0 : err1), 32'(e_err));
        check({tag, " fail_vec"}, 32'(sel ? fail0 : fail1), 32'(e_fail));
    endtask

    // sel=0 drives the SETTLE=1 instance, sel=1 the SETTLE=0 instance.
    task automatic sweep(input bit sel, input int poke_vec, input logic [2:0] e_err,
                         input logic [3:0] e_fail, input logic e_pass, input string tag);
        int settle;
        settle = sel ? 0 : 1;
        @(posedge clk); #1;
        if (sel) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0; start1 = 1'b0;
        for (int v = 0; v < 4; v++) begin
            for (int c = 0; c <= settle; c++) begin
                check({tag, " stim"}, 32'(sel ? stim0 : stim1), 32'(v));
                check({tag, " busy"}, 32'(sel ? busy0 : busy1), 32'd1);
                check({tag, " done early"}, 32'(sel ? done0 : done1), 32'd0);
                if (v == poke_vec && c == 0) begin
                    if (sel) start0 = 1'b1; else start1 = 1'b1;
                end
                @(posedge clk); #1;
                start0 = 1'b0; start1 = 1'b0;
            end
        end
        check({tag, " done pulse"}, 32'(sel ? done0 : done1), 32'd1);
        check({tag, " busy in done"}, 32'(sel ? busy0 : busy1), 32'd0);
        check({tag, " stim in done"}, 32'(sel ? stim0 : stim1), 32'd0);
        check_results(sel, tag, e_err, e_fail, e_pass);
        @(posedge clk); #1;
        check({tag, " done cleared"}, 32'(sel ? done0 : done1), 32'd0);
        check_results(sel, {tag, " held"}, e_err, e_fail, e_pass);
        @(posedge clk); #1;
        check({tag, " idle busy"}, 32'(sel ? busy0 : busy1), 32'd0);
        check({tag, " idle done"}, 32'(sel ? done0 : done1), 32'd0);
    endtask

    initial begin
        tbl[0] = '{mode: 0, err: 3'd0, fail: 4'b0000, pass: 1'b1};
        tbl[1] = '{mode: 1, err: 3'd2, fail: 4'b0110, pass: 1'b0};
        tbl[2] = '{mode: 2, err: 3'd1, fail: 4'b0001, pass: 1'b0};
        tbl[3] = '{mode: 3, err: 3'd3, fail: 4'b1110, pass: 1'b0};

        rst = 1'b1; start1 = 1'b0; start0 = 1'b0; mode = 0;
        #12;
        check("reset stim", 32'(stim1), 32'd0);
        check("reset busy", 32'(busy1), 32'd0);
        check("reset done", 32'(done1), 32'd0);
        check_results(1'b0, "reset", 3'd0, 4'b0000, 1'b0);
        check_results(1'b1, "reset s0", 3'd0, 4'b0000, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            mode = tbl[i].mode;
            sweep(1'b0, -1, tbl[i].err, tbl[i].fail, tbl[i].pass, $sformatf("tbl%0d", i));
        end

        // start pulsed during vector 2 must be ignored
        mode = 0;
        sweep(1'b0, 2, 3'd0, 4'b0000, 1'b1, "poke");

        // async reset mid-sweep during vector 1, after vector 0 already failed
        mode = 2;
        @(posedge clk); #1; start1 = 1'b1;
        @(posedge clk); #1; start1 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre-rst stim", 32'(stim1), 32'd1);
        check("pre-rst err_count", 32'(err1), 32'd1);
        #2; rst = 1'b1; #1;
        check("async rst stim", 32'(stim1), 32'd0);
        check("async rst busy", 32'(busy1), 32'd0);
        check("async rst done", 32'(done1), 32'd0);
        check_results(1'b0, "async rst", 3'd0, 4'b0000, 1'b0);
        @(posedge clk); #1; rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("post-rst done", 32'(done1), 32'd0);
            check("post-rst busy", 32'(busy1), 32'd0);
            @(posedge clk); #1;
        end
        mode = 0;
        sweep(1'b0, -1, 3'd0, 4'b0000, 1'b1, "after rst");

        // SETTLE=0: OR, then AND twice to show counters clear at each start
        mode = 0;
        sweep(1'b1, -1, 3'd0, 4'b0000, 1'b1, "s0 or");
        mode = 1;
        sweep(1'b1, -1, 3'd2, 4'b0110, 1'b0, "s0 and");
        sweep(1'b1, -1, 3'd2, 4'b0110, 1'b0, "s0 and again");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
